// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
// Covers the FSM states, the Booth digit code and the iteration count.
package booth_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // {Q[1], Q[0], q_m1}
   typedef logic [2:0] booth_code_t;

   function automatic int iter_count(input int width);
      return (width / 2) + 1;
   endfunction

endpackage

// File: rtl/booth_r4_multiplier_if.sv
// Operand and product valid/ready handshake bundle for the Booth multiplier.
// The master side is the source/sink and the slave side is the multiplier.
interface booth_r4_multiplier_if #(
   parameter int MUL_WIDTH = 16
);
   logic                       src_valid;
   logic                       src_ready;
   logic [MUL_WIDTH-1:0]       multiplicand;
   logic [MUL_WIDTH-1:0]       multiplier;
   logic                       op_signed;
   logic                       dest_valid;
   logic                       dest_ready;
   logic [2*MUL_WIDTH-1:0]     product;

   modport master (
      output src_valid,
      input  src_ready,
      output multiplicand,
      output multiplier,
      output op_signed,
      input  dest_valid,
      output dest_ready,
      input  product
   );

   modport slave (
      input  src_valid,
      output src_ready,
      input  multiplicand,
      input  multiplier,
      input  op_signed,
      output dest_valid,
      input  dest_ready,
      output product
   );
endinterface

// File: rtl/booth_r4_digit.sv
// Combinational radix-4 Booth recoder.
// Turns {Q[1],Q[0],q_m1} and the extended multiplicand into a signed addend.
module booth_r4_digit
   import booth_mul_pkg::*;
#(
   parameter int MUL_WIDTH = 16
) (
   input  booth_code_t            code,
   input  logic [MUL_WIDTH+1:0]   m,
   output logic [MUL_WIDTH+2:0]   addend
);
   localparam int ACC_W = MUL_WIDTH + 3;

   logic [ACC_W-1:0] m1_s;
   logic [ACC_W-1:0] m2_s;

   assign m1_s = {m[MUL_WIDTH+1], m};
   assign m2_s = {m, 1'b0};

   // select 0, +-M or +-2M from the Booth code
   always_comb begin
      addend = {ACC_W{1'b0}};
      case (code)
         3'b000, 3'b111: addend = {ACC_W{1'b0}};
         3'b001, 3'b010: addend = m1_s;
         3'b011:         addend = m2_s;
         3'b100:         addend = -m2_s;
         3'b101, 3'b110: addend = -m1_s;
         default:        addend = {ACC_W{1'b0}};
      endcase
   end
endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per transaction.
// One Booth step per cycle; the result is held until the sink accepts it.
module booth_r4_multiplier
   import booth_mul_pkg::*;
#(
   parameter int MUL_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   booth_r4_multiplier_if.slave bus
);
   localparam int EXT_W = MUL_WIDTH + 2;
   localparam int ACC_W = MUL_WIDTH + 3;
   localparam int TOT_W = ACC_W + EXT_W + 1;
   localparam int ITER  = iter_count(MUL_WIDTH);
   localparam int CNT_W = $clog2(ITER + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

   state_t                  state_r;
   logic [EXT_W-1:0]        m_r;
   logic [ACC_W-1:0]        p_r;
   logic [EXT_W-1:0]        q_r;
   logic                    qm1_r;
   logic [CNT_W-1:0]        cnt_r;
   logic                    dest_valid_r;
   logic [2*MUL_WIDTH-1:0]  product_r;

   logic                    src_ready_s;
   logic                    accept_s;
   logic [EXT_W-1:0]        ext_a_s;
   logic [EXT_W-1:0]        ext_b_s;
   booth_code_t             code_s;
   logic [ACC_W-1:0]        addend_s;
   logic [ACC_W-1:0]        p_sum_s;
   logic [TOT_W-1:0]        acc_shift_s;

   // accepting a new pair while DONE relies on dest_ready in the same cycle
   always_comb begin
      src_ready_s = 1'b0;
      case (state_r)
         IDLE:    src_ready_s = 1'b1;
         DONE:    src_ready_s = bus.dest_ready;
         default: src_ready_s = 1'b0;
      endcase
   end

   assign accept_s = bus.src_valid & src_ready_s;

   // widen operands by two bits so unsigned values stay positive
   always_comb begin
      if (bus.op_signed) begin
         ext_a_s = {{2{bus.multiplicand[MUL_WIDTH-1]}}, bus.multiplicand};
         ext_b_s = {{2{bus.multiplier[MUL_WIDTH-1]}}, bus.multiplier};
      end else begin
         ext_a_s = {2'b00, bus.multiplicand};
         ext_b_s = {2'b00, bus.multiplier};
      end
   end

   assign code_s = {q_r[1:0], qm1_r};

   booth_r4_digit #(
      .MUL_WIDTH (MUL_WIDTH)
   ) u_digit (
      .code   (code_s),
      .m      (m_r),
      .addend (addend_s)
   );

   assign p_sum_s     = p_r + addend_s;
   assign acc_shift_s = $signed({p_sum_s, q_r, qm1_r}) >>> 2;

   // FSM, accumulator and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         m_r          <= {EXT_W{1'b0}};
         p_r          <= {ACC_W{1'b0}};
         q_r          <= {EXT_W{1'b0}};
         qm1_r        <= 1'b0;
         cnt_r        <= {CNT_W{1'b0}};
         dest_valid_r <= 1'b0;
         product_r    <= {(2*MUL_WIDTH){1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  m_r     <= ext_a_s;
                  q_r     <= ext_b_s;
                  p_r     <= {ACC_W{1'b0}};
                  qm1_r   <= 1'b0;
                  cnt_r   <= {CNT_W{1'b0}};
                  state_r <= CALC;
               end else begin
                  state_r <= IDLE;
               end
            end
            CALC: begin
               p_r   <= acc_shift_s[TOT_W-1 -: ACC_W];
               q_r   <= acc_shift_s[EXT_W:1];
               qm1_r <= acc_shift_s[0];
               cnt_r <= cnt_r + CNT_W'(1);
               if (cnt_r == LAST_CNT) begin
                  product_r    <= acc_shift_s[2*MUL_WIDTH:1];
                  dest_valid_r <= 1'b1;
                  state_r      <= DONE;
               end else begin
                  state_r <= CALC;
               end
            end
            DONE: begin
               if (bus.dest_ready) begin
                  dest_valid_r <= 1'b0;
                  if (bus.src_valid) begin
                     m_r     <= ext_a_s;
                     q_r     <= ext_b_s;
                     p_r     <= {ACC_W{1'b0}};
                     qm1_r   <= 1'b0;
                     cnt_r   <= {CNT_W{1'b0}};
                     state_r <= CALC;
                  end else begin
                     state_r <= IDLE;
                  end
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r      <= IDLE;
               dest_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.src_ready  = src_ready_s;
   assign bus.dest_valid = dest_valid_r;
   assign bus.product    = product_r;
endmodule
